// File: rtl/romulus_round_sched.sv
// rtl/romulus_round_sched.sv - round sequencer for the SKINNY-128-384+ TBC datapath.
// Optional randomness gating before every round: define ROMULUS_RDI_GATE_EN.
module romulus_round_sched #(
   parameter int CLKS_PER_RND = 4,
   parameter int NUM_RNDS     = 40,
   parameter int CONSTW       = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    hold,
   input  logic                    rdi_valid,
   output logic                    rdi_ready,
   output logic                    share_en,
   output logic [CLKS_PER_RND-1:0] enrnd,
   output logic [CONSTW-1:0]       constant,
   output logic [5:0]              round_idx,
   output logic                    last_rnd,
   output logic                    busy,
   output logic                    done
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WAIT_RDI = 2'd1;
   localparam logic [1:0] S_RUN      = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   localparam logic [5:0]              LAST_RND    = 6'(NUM_RNDS - 1);
   localparam logic [CLKS_PER_RND-1:0] PHASE_FIRST = CLKS_PER_RND'(1);
   localparam logic [CONSTW-1:0]       RC_INIT     = CONSTW'(1);

   logic [1:0]              state;
   logic [CLKS_PER_RND-1:0] phase;
   logic [CLKS_PER_RND-1:0] phase_rot;
   logic [5:0]              rnd;
   logic [CONSTW-1:0]       rc;
   logic [CONSTW-1:0]       rc_next;

   // Rotate-left written with shifts so a single-phase round (width 1) stays at 1.
   assign phase_rot = (phase << 1) | (phase >> (CLKS_PER_RND - 1));
   assign rc_next   = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};

`ifdef ROMULUS_RDI_GATE_EN
   assign rdi_ready = (state == S_WAIT_RDI) && !hold;
   assign share_en  = rdi_ready && rdi_valid;
`else
   logic unused_rdi;
   assign unused_rdi = rdi_valid;
   assign rdi_ready  = 1'b0;
   assign share_en   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         phase <= '0;
         rnd   <= '0;
         rc    <= RC_INIT;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !hold) begin
                  rnd <= '0;
                  rc  <= RC_INIT;
`ifdef ROMULUS_RDI_GATE_EN
                  state <= S_WAIT_RDI;
                  phase <= '0;
`else
                  state <= S_RUN;
                  phase <= PHASE_FIRST;
`endif
               end
            end
            S_WAIT_RDI: begin
               if (share_en) begin
                  state <= S_RUN;
                  phase <= PHASE_FIRST;
               end
            end
            S_RUN: begin
               if (!hold) begin
                  if (phase[CLKS_PER_RND-1]) begin
                     if (rnd == LAST_RND) begin
                        state <= S_DONE;
                        phase <= '0;
                     end else begin
                        rnd <= rnd + 6'd1;
                        rc  <= rc_next;
`ifdef ROMULUS_RDI_GATE_EN
                        state <= S_WAIT_RDI;
                        phase <= '0;
`else
                        phase <= PHASE_FIRST;
`endif
                     end
                  end else begin
                     phase <= phase_rot;
                  end
               end
            end
            default: begin
               // DONE lasts one cycle regardless of hold; leaving it re-arms the counters.
               state <= S_IDLE;
               rnd   <= '0;
               rc    <= RC_INIT;
            end
         endcase
      end
   end

   assign enrnd     = (state == S_RUN && !hold) ? phase : '0;
   assign constant  = rc;
   assign round_idx = rnd;
   assign busy      = (state == S_RUN) || (state == S_WAIT_RDI);
   assign done      = (state == S_DONE);
   assign last_rnd  = busy && (rnd == LAST_RND);

endmodule

// File: tb/tb_romulus_round_sched.sv
// tb/tb_romulus_round_sched.sv - directed self-checking bench for romulus_round_sched.
module tb_romulus_round_sched;

   logic       clk = 1'b0;
   logic       rst, start, hold, rdi_valid;
   logic       rdi_ready, share_en, last_rnd, busy, done;
   logic [3:0] enrnd;
   logic [5:0] constant, round_idx;

   int vectors = 0;
   int errors  = 0;

   logic [5:0] rc_tab [40] = '{
      6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
      6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
      6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
      6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};

   always #5 clk = ~clk;

   romulus_round_sched dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hold      (hold),
      .rdi_valid (rdi_valid),
      .rdi_ready (rdi_ready),
      .share_en  (share_en),
      .enrnd     (enrnd),
      .constant  (constant),
      .round_idx (round_idx),
      .last_rnd  (last_rnd),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_enrnd"}, 32'(enrnd), 32'h0);
      check({tag, "_const"}, 32'(constant), 32'h01);
      check({tag, "_ridx"}, 32'(round_idx), 32'h0);
      check({tag, "_last"}, 32'(last_rnd), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
      check({tag, "_rdy"}, 32'(rdi_ready), 32'h0);
      check({tag, "_shen"}, 32'(share_en), 32'h0);
   endtask

   // Start at cycle 0, then check every cycle against the ungated schedule.
   task automatic run_check(input int hold_at, input int hold_len, input bit poke, input int abort_at);
      int c, e, held, r;
      start = 1'b1;
      hold  = 1'b0;
      tick();
      c    = 1;
      held = 0;
      while (c < 400) begin
         hold      = (c >= hold_at) && (c < hold_at + hold_len);
         start     = poke && (c == 50 || c - held == 161);
         rdi_valid = c[0];
         if (c == abort_at) begin
            start = 1'b0;
            rst   = 1'b1;
            tick();
            rst = 1'b0;
            check_idle("abort");
            return;
         end
         #1;
         e = c - held;
         r = (e - 1) / 4;
         if (hold) begin
            check("hold_enrnd", 32'(enrnd), 32'h0);
            check("hold_ridx", 32'(round_idx), 32'(r));
            check("hold_busy", 32'(busy), 32'h1);
            held++;
         end else if (e <= 160) begin
            check("run_enrnd", 32'(enrnd), 32'(1 << ((e - 1) % 4)));
            check("run_const", 32'(constant), 32'(rc_tab[r]));
            check("run_ridx", 32'(round_idx), 32'(r));
            check("run_last", 32'(last_rnd), 32'(r == 39));
            check("run_busy", 32'(busy), 32'h1);
            check("run_done", 32'(done), 32'h0);
            check("run_rdy", 32'(rdi_ready), 32'h0);
            check("run_shen", 32'(share_en), 32'h0);
         end else begin
            check("done_pulse", 32'(done), 32'h1);
            check("done_cycle", 32'(c), 32'(161 + hold_len));
            check("done_busy", 32'(busy), 32'h0);
            check("done_enrnd", 32'(enrnd), 32'h0);
            check("done_const", 32'(constant), 32'h1A);
            check("done_ridx", 32'(round_idx), 32'd39);
            tick();
            start = 1'b0;
            hold  = 1'b0;
            #1;
            check_idle("post_done");
            return;
         end
         tick();
         c++;
      end
      check("run_bound", 32'(c), 32'h0);
   endtask

`ifdef ROMULUS_RDI_GATE_EN
   task automatic run_rdi();
      int c, pulses;
      rdi_valid = 1'b0;
      start     = 1'b1;
      tick();
      start  = 1'b0;
      c      = 1;
      pulses = 0;
      while (c < 400) begin
         rdi_valid = (c >= 10);
         #1;
         if (c < 10) begin
            check("wait_enrnd", 32'(enrnd), 32'h0);
            check("wait_rdy", 32'(rdi_ready), 32'h1);
            check("wait_busy", 32'(busy), 32'h1);
            check("wait_shen", 32'(share_en), 32'h0);
         end
         if (c == 10) check("first_shen", 32'(share_en), 32'h1);
         if (c == 11) check("first_enrnd", 32'(enrnd), 32'h1);
         if (share_en) pulses++;
         if (done) begin
            check("rdi_done_cycle", 32'(c), 32'd210);
            check("rdi_pulses", 32'(pulses), 32'd40);
            tick();
            rdi_valid = 1'b0;
            #1;
            check_idle("rdi_idle");
            return;
         end
         tick();
         c++;
      end
      check("rdi_bound", 32'(c), 32'h0);
   endtask
`endif

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      hold      = 1'b0;
      rdi_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_idle("reset");

      start = 1'b1;
      hold  = 1'b1;
      tick();
      start = 1'b0;
      hold  = 1'b0;
      #1;
      check_idle("start_held");

`ifdef ROMULUS_RDI_GATE_EN
      run_rdi();
`else
      run_check(0, 0, 1'b0, 0);
      run_check(0, 0, 1'b0, 0);
      run_check(23, 3, 1'b0, 0);
      run_check(0, 0, 1'b0, 81);
      run_check(0, 0, 1'b0, 0);
      run_check(0, 0, 1'b1, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
